uart_rx_frame: RTL and testbench

Parametrised UART receive framer: second-generation receiver for the serial I/O subsystem. Runs on the system clock, advanced by an external oversample strobe, and recovers frames with 5–9 data bits, optional even/odd parity and 1 or 2 stop bits. Received words go into a one-entry holding register with a valid/ready handshake, plus per-word error flags (framing, parity, overrun). It sits between the pin synchroniser/pad and the byte FIFO or CSR block.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sampler.sv | 32 +++
 rtl/uart_rx_frame.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes, receiver state encoding, parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int BIT_IDX_W = 4;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Parity bit a transmitter sends for the word; narrower words are zero-extended.
    function automatic logic uart_parity_calc(input logic [8:0] data, input logic [1:0] mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser on rx, then a 3-tap majority filter clocked by tick.
// Latency: 2 clk to rx_sync_o; maj_o covers the three most recent tick samples.
// Backpressure: none, free-running.
module uart_rx_sampler (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic rx_i,
    output logic rx_sync_o,
    output logic maj_o
);

    logic [1:0] sync_q;
    logic [2:0] samp_q;

    // Both registers reset to the idle-high line level so no false start follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            samp_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            if (tick_i) begin
                samp_q <= {samp_q[1:0], sync_q[1]};
            end
        end
    end

    assign rx_sync_o = sync_q[1];
    assign maj_o     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: 5..9 data bits, optional parity, 1/2 stop bits, one-entry holding register.
// Latency: out_valid rises the cycle after the tick carrying the final stop-bit sample.
// Backpressure: word held until out_valid && out_ready; a completion while full drops the word and sets overrun.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 en,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]        CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]        CNT_END  = CW'(OVERSAMPLE - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

    logic rx_sync;
    logic maj;

    uart_rx_sampler u_sampler (
        .clk       (clk),
        .rst       (rst),
        .tick_i    (tick),
        .rx_i      (rx),
        .rx_sync_o (rx_sync),
        .maj_o     (maj)
    );

    rx_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [1:0]             pmode_q, pmode_d;
    logic                   two_stop_q, two_stop_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   frame_done;

    logic [DATA_BITS-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   ferr_out_q, ferr_out_d;
    logic                   perr_out_q, perr_out_d;
    logic                   overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            pmode_q     <= PAR_NONE;
            two_stop_q  <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ferr_out_q  <= 1'b0;
            perr_out_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            pmode_q     <= pmode_d;
            two_stop_q  <= two_stop_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ferr_out_q  <= ferr_out_d;
            perr_out_q  <= perr_out_d;
            overrun_q   <= overrun_d;
        end
    end

    // Frame FSM. The tick counter is a power of two, so it wraps to 0 after CNT_END by itself.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        pmode_d    = pmode_q;
        two_stop_d = two_stop_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;

        if (!en) begin
            state_d = RX_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (tick && !rx_sync) begin
                        state_d = RX_START;
                        cnt_d   = '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CNT_MID) begin
                            cnt_d = '0;
                            if (!maj) begin
                                state_d    = RX_DATA;
                                idx_d      = '0;
                                pmode_d    = (parity_mode == PAR_EVEN || parity_mode == PAR_ODD)
                                             ? parity_mode : PAR_NONE;
                                two_stop_d = two_stop;
                                perr_d     = 1'b0;
                                ferr_d     = 1'b0;
                            end else begin
                                state_d = RX_IDLE;
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CNT_END) begin
                            // LSB arrives first, so shifting in from the top leaves it at bit 0.
                            shift_d = {maj, shift_q[DATA_BITS-1:1]};
                            idx_d   = idx_q + BIT_IDX_W'(1);
                            if (idx_q == LAST_IDX) begin
                                idx_d   = '0;
                                state_d = (pmode_q == PAR_NONE) ? RX_STOP : RX_PARITY;
                            end
                        end
                    end
                end
                RX_PARITY: begin
                    if (tick) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CNT_END) begin
                            perr_d  = (maj != uart_parity_calc(9'(shift_q), pmode_q));
                            state_d = RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CNT_END) begin
                            ferr_d = ferr_q | !maj;
                            if (two_stop_q && idx_q == '0) begin
                                idx_d = BIT_IDX_W'(1);
                            end else begin
                                frame_done = 1'b1;
                                idx_d      = '0;
                                state_d    = maj ? RX_IDLE : RX_BREAK;
                            end
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_sync) begin
                        state_d = RX_IDLE;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    // Holding register: a completion loads only if the slot is empty or drains this same cycle.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        ferr_out_d  = ferr_out_q;
        perr_out_d  = perr_out_q;
        overrun_d   = overrun_q;

        if (frame_done) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shift_q;
                out_valid_d = 1'b1;
                ferr_out_d  = ferr_q | !maj;
                perr_out_d  = perr_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_err  = ferr_out_q;
    assign parity_err = perr_out_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q == RX_DATA) || (state_q == RX_PARITY) || (state_q == RX_STOP);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed frames on an 8-bit and a 7-bit instance, scoreboard per instance.
// Inputs change at negedge (tick) and negedge+1 (line, controls); monitors sample at negedge+2.
// Each scoreboard entry is {frame_err, parity_err, data[8:0]}.
module tb_uart_rx_frame;

    logic clk = 1'b0;
    logic rst, tick, en, out_ready, clr_overrun, two_stop;
    logic [1:0] parity_mode;
    logic rx_drv;
    int   sel;
    logic rx8, rx7;

    logic [7:0] out_data;
    logic       out_valid, frame_err, parity_err, overrun, busy;
    logic [6:0] out_data7;
    logic       out_valid7, frame_err7, parity_err7, overrun7, busy7;

    int errors = 0;
    int checks = 0;
    logic [10:0] q8[$];
    logic [10:0] q7[$];
    int tdiv = 0;

    always #5 clk = ~clk;

    assign rx8 = (sel == 0) ? rx_drv : 1'b1;
    assign rx7 = (sel == 1) ? rx_drv : 1'b1;

    uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .tick(tick), .en(en),
        .parity_mode(parity_mode), .two_stop(two_stop), .rx(rx8),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
        .clr_overrun(clr_overrun), .busy(busy)
    );

    uart_rx_frame #(.DATA_BITS(7), .OVERSAMPLE(16)) dut7 (
        .clk(clk), .rst(rst), .tick(tick), .en(1'b1),
        .parity_mode(parity_mode), .two_stop(two_stop), .rx(rx7),
        .out_data(out_data7), .out_valid(out_valid7), .out_ready(1'b1),
        .frame_err(frame_err7), .parity_err(parity_err7), .overrun(overrun7),
        .clr_overrun(1'b0), .busy(busy7)
    );

    // One tick every 4 clocks.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tdiv = (tdiv + 1) % 4;
            tick = (tdiv == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin : mon8
        logic [10:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w8_unexpected: got data %0h fe %0b pe %0b, expected no word", out_data, frame_err, parity_err);
                end else begin
                    e = q8.pop_front();
                    chk("w8_data", 32'(out_data), 32'(e[8:0]));
                    chk("w8_frame_err", 32'(frame_err), 32'(e[10]));
                    chk("w8_parity_err", 32'(parity_err), 32'(e[9]));
                end
            end
        end
    end

    initial begin : mon7
        logic [10:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid7) begin
                if (q7.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w7_unexpected: got data %0h fe %0b pe %0b, expected no word", out_data7, frame_err7, parity_err7);
                end else begin
                    e = q7.pop_front();
                    chk("w7_data", 32'(out_data7), 32'(e[8:0]));
                    chk("w7_frame_err", 32'(frame_err7), 32'(e[10]));
                    chk("w7_parity_err", 32'(parity_err7), 32'(e[9]));
                end
            end
        end
    end

    task automatic hold(input logic b, input int n);
        rx_drv = b;
        for (int i = 0; i < n;) begin
            @(negedge clk);
            #1;
            if (tick) i++;
        end
    endtask

    task automatic frame(input int s, input logic [8:0] d, input int nb, input bit has_par,
                         input logic pbit, input int nstop, input logic s2);
        sel = s;
        hold(1'b0, 16);
        for (int i = 0; i < nb; i++) hold(d[i], 16);
        if (has_par) hold(pbit, 16);
        hold(1'b1, 16);
        if (nstop == 2) hold(s2, 16);
        hold(1'b1, 16);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation still running, expected summary before time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic g;
        rst = 1'b1; en = 1'b1; out_ready = 1'b1; clr_overrun = 1'b0;
        two_stop = 1'b0; parity_mode = 2'b00; rx_drv = 1'b1; sel = 0;
        wait_cycles(3);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        hold(1'b1, 32);

        // 8N1 0xA5, held until the consumer is ready
        out_ready = 1'b0;
        q8.push_back({1'b0, 1'b0, 9'h0A5});
        frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        chk("a5_valid", 32'(out_valid), 32'd1);
        wait_cycles(20);
        chk("a5_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_cycles(2);
        chk("a5_valid_drop", 32'(out_valid), 32'd0);

        // 8E1 0x03 with parity bit 1 (correct would be 0)
        parity_mode = 2'b01;
        q8.push_back({1'b0, 1'b1, 9'h003});
        frame(0, 9'h003, 8, 1'b1, 1'b1, 1, 1'b1);

        // 7O2 0x55: four ones, so odd parity bit is 1
        parity_mode = 2'b10;
        two_stop = 1'b1;
        q7.push_back({1'b0, 1'b0, 9'h055});
        frame(1, 9'h055, 7, 1'b1, 1'b1, 2, 1'b1);

        // quarter-bit glitch on the idle line
        parity_mode = 2'b00;
        two_stop = 1'b0;
        sel = 0;
        hold(1'b0, 4);
        rx_drv = 1'b1;
        g = 1'b0;
        for (int i = 0; i < 64;) begin
            @(negedge clk);
            #1;
            if (busy) g = 1'b1;
            if (tick) i++;
        end
        chk("glitch_busy", 32'(g), 32'd0);

        // 8N2 0x81 with the second stop bit low
        two_stop = 1'b1;
        q8.push_back({1'b1, 1'b0, 9'h081});
        frame(0, 9'h081, 8, 1'b0, 1'b0, 2, 1'b0);

        // break: line low for three 8N1 frame times, one word only
        two_stop = 1'b0;
        q8.push_back({1'b1, 1'b0, 9'h000});
        hold(1'b0, 480);
        hold(1'b1, 32);

        // overrun: 0x11 kept, 0x22 dropped
        out_ready = 1'b0;
        q8.push_back({1'b0, 1'b0, 9'h011});
        frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
        frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
        chk("overrun_set", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        wait_cycles(1);
        clr_overrun = 1'b0;
        chk("overrun_clr", 32'(overrun), 32'd0);

        // 0x11 accepted in the very cycle 0x66 completes (144 ticks after start validation)
        q8.push_back({1'b0, 1'b0, 9'h066});
        fork
            frame(0, 9'h066, 8, 1'b0, 1'b0, 1, 1'b1);
            begin : align
                int w;
                int n;
                bit seen;
                w = 0; n = 0; seen = 1'b0;
                while (w < 3000 && !seen) begin
                    @(negedge clk);
                    #1;
                    if (busy) seen = 1'b1;
                    else w++;
                end
                if (!seen) begin
                    checks++;
                    errors++;
                    $display("FAIL align_busy: busy never rose, expected 1 within 3000 cycles");
                end else begin
                    while (n < 144) begin
                        if (tick) n++;
                        if (n < 144) begin
                            @(negedge clk);
                            #1;
                        end
                    end
                    out_ready = 1'b1;
                    wait_cycles(1);
                    out_ready = 1'b0;
                end
            end
        join
        chk("coincide_overrun", 32'(overrun), 32'd0);
        chk("coincide_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_cycles(4);

        // en dropped mid-DATA, then a clean 0x3C
        hold(1'b0, 16);
        hold(1'b1, 48);
        chk("en_busy_before", 32'(busy), 32'd1);
        en = 1'b0;
        wait_cycles(1);
        chk("en_busy_after", 32'(busy), 32'd0);
        en = 1'b1;
        hold(1'b1, 48);
        q8.push_back({1'b0, 1'b0, 9'h03C});
        frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);

        // reset mid-DATA, then a clean 0x3C
        hold(1'b0, 16);
        hold(1'b1, 48);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        hold(1'b1, 48);
        q8.push_back({1'b0, 1'b0, 9'h03C});
        frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);

        wait_cycles(100);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q7_drained", 32'(q7.size()), 32'd0);
        chk("dut7_overrun", 32'(overrun7), 32'd0);
        chk("dut7_busy", 32'(busy7), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
